// File: rtl/serial_addsub_pkg.sv
// Shared types for the chunk-serial adder/subtractor: FSM states and op encodings.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// CHUNK-bit combinational ripple-carry adder; also exposes the carry into its top bit
// so the parent can derive signed overflow on the final chunk.
module addsub_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout     = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/serial_addsub.sv
// Chunk-serial add/subtract: CHUNK bits per clock, result after WIDTH/CHUNK cycles.
// Optional build macro SERIAL_ADDSUB_SATURATE_EN clamps the result on signed overflow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (CHUNK < 1 || WIDTH < 2 || WIDTH > 64 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("serial_addsub: WIDTH must be 2..64 and a multiple of CHUNK");
    end
  endgenerate

`ifdef SERIAL_ADDSUB_SATURATE_EN
  // On overflow the wrapped MSB is the inverse of the true sign.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] sum, input logic ovf);
    logic [WIDTH-1:0] r;
    r = sum;
    if (ovf) begin
      r          = sum[WIDTH-1] ? '1 : '0;
      r[WIDTH-1] = ~sum[WIDTH-1];
    end
    return r;
  endfunction
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] x_sel, y_sel, s_w;
  logic             cout_w, cmsb_w;
  logic [WIDTH-1:0] merged;
  logic             last, accept;

  always_comb begin
    x_sel  = '0;
    y_sel  = '0;
    merged = result_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        x_sel                     = a_q[i*CHUNK +: CHUNK];
        y_sel                     = b_q[i*CHUNK +: CHUNK];
        merged[i*CHUNK +: CHUNK]  = s_w;
      end
    end
  end

  addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .x        (x_sel),
    .y        (y_sel),
    .cin      (carry_q),
    .s        (s_w),
    .cout     (cout_w),
    .c_msb_in (cmsb_w)
  );

  assign last     = (cnt_q == CW'(N - 1));
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: ;
      CALC: begin
        carry_d  = cout_w;
        result_d = merged;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          cnt_d   = '0;
          state_d = DONE;
          cout_d  = cout_w;
          ovf_d   = cout_w ^ cmsb_w;
`ifdef SERIAL_ADDSUB_SATURATE_EN
          result_d = saturate(merged, cout_w ^ cmsb_w);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Subtract is a + ~b + 1: invert b once at accept and seed the carry with op.
    if (accept) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{op == OP_SUB}};
      carry_d = (op == OP_SUB);
      cnt_d   = '0;
      state_d = CALC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomized bench for serial_addsub (WIDTH=8, CHUNK=2) against an
// arithmetic reference model.
module tb_serial_addsub;

  localparam int WIDTH = 8;
  localparam int CHUNK = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  int total  = 0;
  int passed = 0;

  serial_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic o, input logic [7:0] x, input logic [7:0] y,
                                output logic [7:0] r, output logic co, output logic ov);
    int sx, sy, t, ux, uy;
    sx = $signed(x);
    sy = $signed(y);
    ux = int'(x);
    uy = int'(y);
    if (o == 1'b0) begin
      t  = sx + sy;
      co = (ux + uy) > 255;
      r  = 8'(ux + uy);
    end else begin
      t  = sx - sy;
      co = (ux >= uy);
      r  = 8'(ux - uy);
    end
    ov = (t > 127) || (t < -128);
`ifdef SERIAL_ADDSUB_SATURATE_EN
    if (ov) r = (t > 0) ? 8'h7F : 8'h80;
`endif
  endfunction

  // Call #1 after the accept edge; counts edges until out_valid is seen.
  task automatic wait_valid(input string tag, input int exp_edges);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (!out_valid) begin
        in_valid = 1'b1;
        a        = 8'($urandom);
        b        = 8'($urandom);
        op       = 1'($urandom);
      end
    end while (!out_valid && k < 10);
    in_valid = 1'b0;
    chk({tag, "_lat"}, 64'(k), 64'(exp_edges));
    chk({tag, "_ovld"}, 64'(out_valid), 64'(1));
  endtask

  task automatic do_op(input string tag, input logic o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic ec, input logic eo);
    @(negedge clk);
    chk({tag, "_inrdy"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_ovld0"}, 64'(out_valid), 64'(0));
    wait_valid(tag, 4);
    chk({tag, "_res"}, 64'(result), 64'(er));
    chk({tag, "_cout"}, 64'(carry_out), 64'(ec));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drain"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    logic [7:0] er, x, y;
    logic       ec, eo, o;
    int         stale;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_ovld", 64'(out_valid), 64'(0));
    chk("rst_res", 64'(result), 64'(0));
    chk("rst_cout", 64'(carry_out), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_inrdy", 64'(in_ready), 64'(1));

    // Directed corner cases
    do_op("sub_eq", 1'b1, 8'h31, 8'h31, 8'h00, 1'b1, 1'b0);
`ifdef SERIAL_ADDSUB_SATURATE_EN
    do_op("add_ovf", 1'b0, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1);
    do_op("sub_ovf", 1'b1, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1);
`else
    do_op("add_ovf", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    do_op("sub_ovf", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
`endif
    do_op("sub_brw", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom);
      x = 8'($urandom);
      y = 8'($urandom);
      model(o, x, y, er, ec, eo);
      do_op($sformatf("rnd%0d", i), o, x, y, er, ec, eo);
    end

    // Backpressure in DONE, then back-to-back accept on the release cycle
    x = 8'hC3; y = 8'h5A; o = 1'b0;
    model(o, x, y, er, ec, eo);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid("hold", 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      op = 1'($urandom);
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_ovld", i), 64'(out_valid), 64'(1));
      chk($sformatf("hold%0d_inrdy", i), 64'(in_ready), 64'(0));
      chk($sformatf("hold%0d_res", i), 64'(result), 64'(er));
      chk($sformatf("hold%0d_flags", i), 64'({carry_out, overflow}), 64'({ec, eo}));
    end
    @(negedge clk);
    x = 8'h12; y = 8'h34; o = 1'b0;
    model(o, x, y, er, ec, eo);
    out_ready = 1'b1; in_valid = 1'b1; op = o; a = x; b = y;
    #1;
    chk("b2b_inrdy", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_ovld0", 64'(out_valid), 64'(0));
    wait_valid("b2b", 4);
    chk("b2b_res", 64'(result), 64'(er));
    chk("b2b_flags", 64'({carry_out, overflow}), 64'({ec, eo}));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Asynchronous reset during the second CALC cycle
    @(negedge clk);
    in_valid = 1'b1; op = 1'b0; a = 8'h55; b = 8'h22;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovld", 64'(out_valid), 64'(0));
    chk("mid_rst_res", 64'(result), 64'(0));
    chk("mid_rst_flags", 64'({carry_out, overflow}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_inrdy", 64'(in_ready), 64'(1));
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    chk("mid_no_stale", 64'(stale), 64'(0));

    // Normal operation after the mid-flight reset
    model(1'b1, 8'h20, 8'h45, er, ec, eo);
    do_op("post_rst", 1'b1, 8'h20, 8'h45, er, ec, eo);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
